// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control FSM.
// Covers the state enum, ALU op codes, opcodes, select encodings and branch evaluation.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JAL2,
    S_ILLEGAL
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] RES_PC      = 2'b11;

  typedef struct packed {
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // Returns {valid, taken}; blt/bge look only at the raw sign bit, no overflow fix-up.
  function automatic logic [1:0] branch_eval(input logic [2:0] funct3,
                                             input logic       zero,
                                             input logic       sign);
    logic [1:0] r;
    r = 2'b00;
    case (funct3)
      F3_BEQ:  r = {1'b1, zero};
      F3_BNE:  r = {1'b1, ~zero};
      F3_BLT:  r = {1'b1, sign};
      F3_BGE:  r = {1'b1, ~sign};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational funct3/funct7 to ALU op mapping for the execute states.
// valid is low for funct3 codes the shared ALU cannot perform (SLT family).
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [3:0] alu_ctrl,
  output logic       valid
);

  always_comb begin
    alu_ctrl = ALU_AND;
    valid    = 1'b1;
    case (funct3)
      // addi ignores IR[30]; only the R-type form can select SUB
      3'b000:  alu_ctrl = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_ctrl = ALU_SLL;
      3'b100:  alu_ctrl = ALU_XOR;
      3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_ctrl = ALU_OR;
      3'b111:  alu_ctrl = ALU_AND;
      default: begin
        alu_ctrl = ALU_AND;
        valid    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback
// and steers the shared ALU. Outputs are decoded from state; alu_ctrl also uses the latched funct fields.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_ready,
  output logic [3:0] alu_ctrl,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  localparam int unsigned HOLD_W = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;

  state_t            state;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [2:0]        funct3_q;
  logic              funct7_5_q;
  logic              store_q;
  logic [3:0]        dec_ctrl;
  logic              dec_valid;
  logic              br_valid;
  logic              br_taken;
  ctrl_t             ctrl;

  mc_alu_decoder u_alu_decoder (
    .funct3   (funct3_q),
    .funct7_5 (funct7_5_q),
    .is_rtype (state == S_EXEC_R),
    .alu_ctrl (dec_ctrl),
    .valid    (dec_valid)
  );

  assign {br_valid, br_taken} = branch_eval(funct3_q, zero, sign);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == S_IDLE) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  // Instruction fields are captured once in decode so later states do not depend on IR timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q   <= '0;
      funct7_5_q <= 1'b0;
      store_q    <= 1'b0;
    end else if (state == S_DECODE) begin
      funct3_q   <= funct3;
      funct7_5_q <= funct7_5;
      store_q    <= (opcode == OP_STORE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (hold_cnt == HOLD_W'(RESET_PC_HOLD - 1)) state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXEC_R;
          OP_ITYPE:          state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:           state_next = store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:            if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:            state_next = S_FETCH;
      S_MEMWR:            if (mem_ready) state_next = S_FETCH;
      S_EXEC_R, S_EXEC_I: state_next = dec_valid ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:            state_next = S_FETCH;
      S_BRANCH:           state_next = br_valid ? S_FETCH : S_ILLEGAL;
      S_JAL:              state_next = S_JAL2;
      S_JAL2:             state_next = S_FETCH;
      S_ILLEGAL:          state_next = S_FETCH;
      default:            state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl     = '0;
    alu_ctrl = ALU_AND;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.mem_read   = 1'b1;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
        alu_ctrl        = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        alu_ctrl       = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        alu_ctrl       = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.adr_src  = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adr_src    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        alu_ctrl       = dec_ctrl;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        alu_ctrl       = dec_ctrl;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = br_valid & br_taken;
        ctrl.instr_done = br_valid;
        alu_ctrl        = ALU_SUB;
      end
      // jal is split so the link write and the PC write use different result selects
      S_JAL: begin
        ctrl.result_src = RES_PC;
        ctrl.reg_write  = 1'b1;
      end
      S_JAL2: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ILLEGAL: ctrl.illegal = 1'b1;
      default: ;
    endcase
  end

  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign adr_src    = ctrl.adr_src;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign reg_write  = ctrl.reg_write;
  assign instr_done = ctrl.instr_done;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: each instruction is expanded into its expected per-cycle
// control vectors from the instruction class, memory wait counts and branch flags.
module tb_mc_control;

  localparam int unsigned HOLD = 1;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_BAD = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        sign;
  logic        mem_ready;
  logic [3:0]  alu_ctrl;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic        adr_src;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        instr_done;
  logic        illegal;
  logic [17:0] dut_vec;

  int          checks = 0;
  int          errors = 0;
  logic [6:0]  ir_op;
  logic [2:0]  ir_f3;
  logic        ir_f7;

  always #5 clk = ~clk;

  mc_control #(.RESET_PC_HOLD(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .sign       (sign),
    .mem_ready  (mem_ready),
    .alu_ctrl   (alu_ctrl),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .adr_src    (adr_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  assign dut_vec = {alu_ctrl, alu_src_a, alu_src_b, result_src, adr_src, mem_read, mem_write,
                    ir_write, pc_write, reg_write, instr_done, illegal};

  // Vector layout: alu | srcA | srcB | res | adr mr mw irw pcw rw done ill
  function automatic logic [17:0] v(input logic [3:0] alu, input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] rs, input logic adr, input logic mr,
                                    input logic mw, input logic irw, input logic pcw,
                                    input logic rw, input logic dn, input logic il);
    return {alu, sa, sb, rs, adr, mr, mw, irw, pcw, rw, dn, il};
  endfunction

  function automatic logic [3:0] refAlu(input logic [2:0] f3, input logic f7, input logic isr,
                                        output logic ok);
    ok = 1'b1;
    case (f3)
      3'd0:    return (isr && f7) ? 4'b0110 : 4'b0010;
      3'd1:    return 4'b0011;
      3'd4:    return 4'b1000;
      3'd5:    return f7 ? 4'b1011 : 4'b1010;
      3'd6:    return 4'b0001;
      3'd7:    return 4'b0000;
      default: begin
        ok = 1'b0;
        return 4'b0000;
      end
    endcase
  endfunction

  function automatic logic isLegalOp(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  function automatic logic [6:0] randBadOp();
    logic [6:0] op;
    op = 7'($urandom);
    while (isLegalOp(op)) op = 7'($urandom);
    return op;
  endfunction

  task automatic checkOutput(input string tag, input logic [17:0] actual, input logic [17:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", tag, $time, actual, expected);
    end
  endtask

  task automatic step(input logic r, input logic mr, input logic z, input logic s,
                      input logic [17:0] exp, input string tag);
    @(negedge clk);
    rst       = r;
    mem_ready = mr;
    zero      = z;
    sign      = s;
    opcode    = ir_op;
    funct3    = ir_f3;
    funct7_5  = ir_f7;
    #1;
    checkOutput(tag, dut_vec, exp);
  endtask

  task automatic cyc(input logic mr, input logic [17:0] exp, input string tag);
    step(1'b0, mr, 1'($urandom), 1'($urandom), exp, tag);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 18'd0, "reset");
    for (int i = 0; i < int'(HOLD); i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 18'd0, "idle");
  endtask

  task automatic doFetch(input int fw);
    ir_op = 7'($urandom);
    ir_f3 = 3'($urandom);
    ir_f7 = 1'($urandom);
    for (int i = 0; i < fw; i++)
      cyc(1'b0, v(4'b0010, 2'b00, 2'b10, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0), "fetch_wait");
    cyc(1'b1, v(4'b0010, 2'b00, 2'b10, 2'b10, 0, 1, 0, 1, 1, 0, 0, 0), "fetch_ack");
  endtask

  task automatic doDecode(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    ir_op = op;
    ir_f3 = f3;
    ir_f7 = f7;
    cyc(1'($urandom), v(4'b0010, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
  endtask

  task automatic illegalCycle();
    cyc(1'($urandom), v(4'b0000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1), "illegal");
  endtask

  task automatic applyStimulus(input int cls, input logic [2:0] f3, input logic f7,
                               input logic z, input logic s, input int fw, input int mw,
                               input logic [6:0] bad_op);
    logic [6:0] op;
    logic [3:0] aop;
    logic       ok;
    logic       bvalid;
    logic       btaken;
    case (cls)
      C_R:     op = 7'b0110011;
      C_I:     op = 7'b0010011;
      C_LD:    op = 7'b0000011;
      C_ST:    op = 7'b0100011;
      C_BR:    op = 7'b1100011;
      C_JAL:   op = 7'b1101111;
      default: op = bad_op;
    endcase
    doFetch(fw);
    doDecode(op, f3, f7);
    case (cls)
      C_R, C_I: begin
        aop = refAlu(f3, f7, cls == C_R, ok);
        cyc(1'($urandom), v(aop, 2'b10, (cls == C_R) ? 2'b00 : 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0),
            "exec");
        if (ok) cyc(1'($urandom), v(4'b0000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0), "aluwb");
        else    illegalCycle();
      end
      C_LD, C_ST: begin
        cyc(1'($urandom), v(4'b0010, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "memadr");
        if (cls == C_LD) begin
          for (int i = 0; i < mw; i++)
            cyc(1'b0, v(4'b0000, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0), "memrd_wait");
          cyc(1'b1, v(4'b0000, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0), "memrd_ack");
          cyc(1'($urandom), v(4'b0000, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 1, 1, 0), "memwb");
        end else begin
          for (int i = 0; i < mw; i++)
            cyc(1'b0, v(4'b0000, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0), "memwr_wait");
          cyc(1'b1, v(4'b0000, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 1, 0), "memwr_ack");
        end
      end
      C_BR: begin
        bvalid = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
        btaken = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? s : !s;
        step(1'b0, 1'($urandom), z, s,
             v(4'b0110, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, bvalid && btaken, 0, bvalid, 0), "branch");
        if (!bvalid) illegalCycle();
      end
      C_JAL: begin
        cyc(1'($urandom), v(4'b0000, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 1, 0, 0), "jal_link");
        cyc(1'($urandom), v(4'b0000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0), "jal_pc");
      end
      default: illegalCycle();
    endcase
  endtask

  task automatic resetMidLoad(input int stall);
    doFetch($urandom_range(0, 1));
    doDecode(7'b0000011, 3'($urandom), 1'($urandom));
    cyc(1'($urandom), v(4'b0010, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), "memadr");
    for (int i = 0; i < stall; i++)
      cyc(1'b0, v(4'b0000, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0), "memrd_wait");
    doReset(3);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    sign      = 1'b0;
    opcode    = '0;
    funct3    = '0;
    funct7_5  = 1'b0;
    ir_op     = '0;
    ir_f3     = '0;
    ir_f7     = 1'b0;
    doReset(3);

    applyStimulus(C_R,   3'b000, 1'b0, 0, 0, 0, 0, 7'h7F);
    applyStimulus(C_R,   3'b000, 1'b1, 0, 0, 0, 0, 7'h7F);
    applyStimulus(C_LD,  3'b010, 1'b0, 0, 0, 0, 3, 7'h7F);
    applyStimulus(C_BR,  3'b000, 1'b0, 1, 0, 0, 0, 7'h7F);
    applyStimulus(C_BR,  3'b000, 1'b0, 0, 0, 0, 0, 7'h7F);
    applyStimulus(C_BR,  3'b100, 1'b0, 0, 1, 0, 0, 7'h7F);
    applyStimulus(C_BR,  3'b101, 1'b0, 0, 1, 0, 0, 7'h7F);
    applyStimulus(C_BR,  3'b010, 1'b0, 1, 1, 0, 0, 7'h7F);
    applyStimulus(C_I,   3'b101, 1'b1, 0, 0, 0, 0, 7'h7F);
    applyStimulus(C_I,   3'b000, 1'b1, 0, 0, 0, 0, 7'h7F);
    applyStimulus(C_I,   3'b010, 1'b0, 0, 0, 0, 0, 7'h7F);
    applyStimulus(C_BAD, 3'b000, 1'b0, 0, 0, 0, 0, 7'h7F);
    applyStimulus(C_JAL, 3'b000, 1'b0, 0, 0, 1, 0, 7'h7F);
    applyStimulus(C_ST,  3'b010, 1'b0, 0, 0, 2, 2, 7'h7F);
    resetMidLoad(1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0)
        resetMidLoad($urandom_range(0, 3));
      else
        applyStimulus($urandom_range(0, 6), 3'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), randBadOp());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
